// File: rtl/jolt_pkg.sv
// Shared constants and FSM state encoding for the jolt digit-selection core.
package jolt_pkg;

  localparam int BCD_W       = 4;
  localparam int LINES_W     = 12;
  localparam int MAX_K_DEF   = 12;
  localparam int MAX_LEN_DEF = 100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_POP,
    S_CONV,
    S_ACC,
    S_FIN
  } state_t;

endpackage

// File: rtl/bcd_mac.sv
// Decimal multiply-accumulate: result = acc*10 + digit, modulo 2^W.
module bcd_mac
  import jolt_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0]     acc,
  input  logic [BCD_W-1:0] digit,
  output logic [W-1:0]     result
);

  // x*10 as x*8 + x*2, then add the digit
  always_comb result = (acc << 3) + (acc << 1) + W'(digit);

endmodule

// File: rtl/jolt_select_core.sv
// Per line, keeps the lexicographically largest cfg_k-digit subsequence using
// a monotonic stack, converts it to binary and accumulates it into sum.
// Optional input digit checking is enabled by defining JOLT_DIGIT_CHECK_EN.
module jolt_select_core
  import jolt_pkg::*;
#(
  parameter  int MAX_K   = MAX_K_DEF,
  parameter  int MAX_LEN = MAX_LEN_DEF,
  parameter  int SUM_W   = 64,
  localparam int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic               start,
  input  logic [BCD_W-1:0]   cfg_k,
  input  logic [LW-1:0]      cfg_len,
  input  logic [LINES_W-1:0] cfg_lines,
  input  logic               in_valid,
  input  logic [BCD_W-1:0]   in_digit,
  output logic               in_ready,
  output logic               busy,
  output logic               done,
  output logic [SUM_W-1:0]   sum,
  output logic               cfg_err,
  output logic               digit_err
);

  state_t               state;
  logic [BCD_W-1:0]     stack [MAX_K];
  logic [BCD_W-1:0]     depth;
  logic [BCD_W-1:0]     conv_idx;
  logic [BCD_W-1:0]     k_q;
  logic [BCD_W-1:0]     pend;
  logic [LW-1:0]        len_q;
  logic [LW-1:0]        drop;
  logic [LW-1:0]        cnt;
  logic [LINES_W-1:0]   lines_left;
  logic [SUM_W-1:0]     value;
  logic [SUM_W-1:0]     mac_out;
  logic [BCD_W-1:0]     d_in;
  logic [BCD_W-1:0]     top;
  logic [BCD_W-1:0]     res_digit;
  logic                 res_last;
  logic                 pop_cond;
  logic                 cfg_ok;

`ifdef JOLT_DIGIT_CHECK_EN
  logic d_bad;

  // Out-of-range BCD digits are replaced by zero
  always_comb begin
    d_bad = (in_digit > BCD_W'(9));
    d_in  = d_bad ? '0 : in_digit;
  end

  // Sticky digit error, cleared by a valid start
  always_ff @(posedge sysclk) begin
    if (rst)
      digit_err <= 1'b0;
    else if (state == S_IDLE && start && cfg_ok)
      digit_err <= 1'b0;
    else if (state == S_LOAD && in_valid && d_bad)
      digit_err <= 1'b1;
  end
`else
  always_comb begin
    d_in      = in_digit;
    digit_err = 1'b0;
  end
`endif

  // Configuration check and stack-pop decision for the digit being resolved
  always_comb begin
    cfg_ok    = (cfg_k != '0) && (cfg_k <= BCD_W'(MAX_K)) &&
                (cfg_len >= LW'(cfg_k)) && (cfg_len <= LW'(MAX_LEN)) &&
                (cfg_lines != '0);
    top       = (depth != '0) ? stack[depth - BCD_W'(1)] : '0;
    res_digit = (state == S_POP) ? pend : d_in;
    res_last  = (state == S_POP) ? (cnt == len_q) : (cnt + LW'(1) == len_q);
    pop_cond  = (depth != '0) && (top < res_digit) && (drop != '0);
  end

  bcd_mac #(
    .W (SUM_W)
  ) u_mac (
    .acc    (value),
    .digit  (stack[conv_idx]),
    .result (mac_out)
  );

  // Main control FSM with registered handshake/status outputs
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cfg_err  <= 1'b0;
      depth    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sum  <= '0;
            busy <= 1'b1;
            if (cfg_ok) begin
              k_q        <= cfg_k;
              len_q      <= cfg_len;
              lines_left <= cfg_lines;
              drop       <= cfg_len - LW'(cfg_k);
              cnt        <= '0;
              depth      <= '0;
              cfg_err    <= 1'b0;
              in_ready   <= 1'b1;
              state      <= S_LOAD;
            end else begin
              cfg_err <= 1'b1;
              done    <= 1'b1;
              state   <= S_FIN;
            end
          end
        end

        // LOAD accepts a digit; POP keeps retrying the same pending digit.
        // Both share the resolve path (push or discard, then next/convert).
        S_LOAD, S_POP: begin
          if (state == S_POP || in_valid) begin
            if (state == S_LOAD)
              cnt <= cnt + LW'(1);
            if (pop_cond) begin
              if (state == S_LOAD) begin
                pend     <= d_in;
                in_ready <= 1'b0;
                state    <= S_POP;
              end else begin
                depth <= depth - BCD_W'(1);
                drop  <= drop - LW'(1);
              end
            end else begin
              if (depth < k_q) begin
                stack[depth] <= res_digit;
                depth        <= depth + BCD_W'(1);
              end else begin
                drop <= drop - LW'(1);
              end
              if (res_last) begin
                in_ready <= 1'b0;
                conv_idx <= '0;
                value    <= '0;
                state    <= S_CONV;
              end else begin
                in_ready <= 1'b1;
                state    <= S_LOAD;
              end
            end
          end
        end

        S_CONV: begin
          value    <= mac_out;
          conv_idx <= conv_idx + BCD_W'(1);
          if (conv_idx == k_q - BCD_W'(1))
            state <= S_ACC;
        end

        S_ACC: begin
          sum        <= sum + value;
          depth      <= '0;
          drop       <= len_q - LW'(k_q);
          cnt        <= '0;
          lines_left <= lines_left - LINES_W'(1);
          if (lines_left == LINES_W'(1)) begin
            done  <= 1'b1;
            state <= S_FIN;
          end else begin
            in_ready <= 1'b1;
            state    <= S_LOAD;
          end
        end

        S_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jolt_select_core.sv
// Scoreboard bench for jolt_select_core: jobs push their expected result,
// a monitor pops and compares whenever done pulses.
module tb_jolt_select_core;

  logic        sysclk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  cfg_k;
  logic [6:0]  cfg_len;
  logic [11:0] cfg_lines;
  logic        in_valid;
  logic [3:0]  in_digit;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic [63:0] sum;
  logic        cfg_err;
  logic        digit_err;

  jolt_select_core #(
    .MAX_K   (12),
    .MAX_LEN (100),
    .SUM_W   (64)
  ) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .start     (start),
    .cfg_k     (cfg_k),
    .cfg_len   (cfg_len),
    .cfg_lines (cfg_lines),
    .in_valid  (in_valid),
    .in_digit  (in_digit),
    .in_ready  (in_ready),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cfg_err   (cfg_err),
    .digit_err (digit_err)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [63:0] sum;
    logic        cerr;
    logic        derr;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned n_done = 0;
  int unsigned n_jobs = 0;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
  endtask

  task automatic expect_job(input string tag, input logic [63:0] s, input logic ce, input logic de);
    exp_t e;
    e.sum = s; e.cerr = ce; e.derr = de; e.tag = tag;
    exp_q.push_back(e);
    n_jobs++;
  endtask

  // Monitor: compare each done pulse against the oldest expected job
  always @(negedge sysclk) begin
    if (!rst && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done with sum 0x%0h, want no done", sum);
      end else begin
        cur = exp_q.pop_front();
        check64({cur.tag, "_sum"}, sum, cur.sum);
        check64({cur.tag, "_cfg_err"}, {63'd0, cfg_err}, {63'd0, cur.cerr});
        check64({cur.tag, "_digit_err"}, {63'd0, digit_err}, {63'd0, cur.derr});
      end
    end
  end

  task automatic do_start(input int k, input int len, input int lines);
    @(negedge sysclk);
    start = 1'b1; cfg_k = 4'(k); cfg_len = 7'(len); cfg_lines = 12'(lines);
    @(posedge sysclk);
    #1 start = 1'b0;
  endtask

  task automatic send_digit(input logic [3:0] d, input int gap);
    int unsigned n;
    bit got;
    if (gap > 0) begin
      repeat (gap) @(posedge sysclk);
      #1;
    end
    in_valid = 1'b1; in_digit = d;
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(negedge sysclk);
      if (in_ready) begin
        @(posedge sysclk);
        #1 got = 1'b1;
      end
      n++;
    end
    in_valid = 1'b0;
    if (!got) begin
      n_total++;
      $display("FAIL accept_timeout: got no in_ready for digit %0d, want acceptance", d);
    end
  endtask

  task automatic feed_str(input string s, input int gap_max);
    byte c;
    logic [3:0] d;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      d = (c >= 8'h41) ? 4'(c - 8'h41 + 8'd10) : 4'(c - 8'h30);
      send_digit(d, (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    end
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n;
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (busy && n < 5000);
    if (busy) begin
      n_total++;
      $display("FAIL %s_timeout: got busy=1 after %0d cycles, want idle", tag, n);
    end
  endtask

  // Reference: greedy window selection of the largest k-digit subsequence
  function automatic longint unsigned best_k(input int unsigned dg[100], input int unsigned len,
                                             input int unsigned k);
    longint unsigned v;
    int unsigned st;
    int unsigned bi;
    v = 0; st = 0;
    for (int unsigned j = 0; j < k; j++) begin
      bi = st;
      for (int unsigned i = st; i <= len - k + j; i++)
        if (dg[i] > dg[bi]) bi = i;
      v = v * 10 + longint'(dg[bi]);
      st = bi + 1;
    end
    return v;
  endfunction

  string lines4[4] = '{"987654321111111", "811111111111119", "234234234234278", "818181911112111"};
  int unsigned dg[100];
  longint unsigned exp_long;
  bit saw_ready;

  initial begin
    rst = 1'b1; start = 1'b0; cfg_k = '0; cfg_len = '0; cfg_lines = '0;
    in_valid = 1'b0; in_digit = '0;
    repeat (3) @(posedge sysclk);
    #1 rst = 1'b0;
    @(negedge sysclk);
    check64("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check64("rst_busy", {63'd0, busy}, 64'd0);
    check64("rst_done", {63'd0, done}, 64'd0);
    check64("rst_sum", sum, 64'd0);
    check64("rst_cfg_err", {63'd0, cfg_err}, 64'd0);
    check64("rst_digit_err", {63'd0, digit_err}, 64'd0);

    // k=2 over four 15-digit lines: 98+89+78+92
    expect_job("k2", 64'd357, 1'b0, 1'b0);
    do_start(2, 15, 4);
    check64("k2_busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 4; i++) feed_str(lines4[i], 0);
    wait_idle("k2");
    repeat (4) @(negedge sysclk);
    check64("k2_sum_hold", sum, 64'd357);

    // k=12 over the same lines
    expect_job("k12", 64'd3121910778619, 1'b0, 1'b0);
    do_start(12, 15, 4);
    for (int i = 0; i < 4; i++) feed_str(lines4[i], 0);
    wait_idle("k12");

    // Five 100-digit lines, k=12
    exp_long = 0;
    for (int ln = 0; ln < 5; ln++) begin
      for (int i = 0; i < 100; i++) dg[i] = (i * 7 + ln * 13 + (i * i * 3) % 11) % 10;
      exp_long += best_k(dg, 100, 12);
    end
    expect_job("len100", exp_long, 1'b0, 1'b0);
    do_start(12, 100, 5);
    for (int ln = 0; ln < 5; ln++)
      for (int i = 0; i < 100; i++)
        send_digit(4'((i * 7 + ln * 13 + (i * i * 3) % 11) % 10), 0);
    wait_idle("len100");

    // Invalid configurations: k above max, len shorter than k
    expect_job("k13", 64'd0, 1'b1, 1'b0);
    do_start(13, 15, 1);
    saw_ready = 1'b0;
    repeat (6) begin
      @(negedge sysclk);
      if (in_ready) saw_ready = 1'b1;
    end
    check64("k13_no_ready", {63'd0, saw_ready}, 64'd0);
    expect_job("len5k6", 64'd0, 1'b1, 1'b0);
    do_start(6, 5, 1);
    saw_ready = 1'b0;
    repeat (6) begin
      @(negedge sysclk);
      if (in_ready) saw_ready = 1'b1;
    end
    check64("len5k6_no_ready", {63'd0, saw_ready}, 64'd0);

    // Digit 0xA in "91A"
`ifdef JOLT_DIGIT_CHECK_EN
    expect_job("d91A", 64'd910, 1'b0, 1'b1);
`else
    expect_job("d91A", 64'd920, 1'b0, 1'b0);
`endif
    do_start(3, 3, 1);
    feed_str("91A", 0);
    wait_idle("d91A");

    // Random in_valid gaps, plus a start pulse mid-job that must be ignored
    expect_job("gaps", 64'd357, 1'b0, 1'b0);
    do_start(2, 15, 4);
    @(negedge sysclk);
    check64("gaps_digit_err_clr", {63'd0, digit_err}, 64'd0);
    check64("gaps_cfg_err_clr", {63'd0, cfg_err}, 64'd0);
    feed_str(lines4[0], 5);
    do_start(13, 15, 1);
    for (int i = 1; i < 4; i++) feed_str(lines4[i], 5);
    wait_idle("gaps");

    // Reset while popping on line 2, then a clean one-line job
    do_start(2, 15, 4);
    feed_str(lines4[0], 0);
    feed_str(lines4[1], 0);
    @(negedge sysclk);
    check64("pop_stall_ready", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge sysclk);
    #1 rst = 1'b0;
    @(negedge sysclk);
    check64("midpop_busy", {63'd0, busy}, 64'd0);
    check64("midpop_in_ready", {63'd0, in_ready}, 64'd0);
    check64("midpop_sum", sum, 64'd0);
    expect_job("after_rst", 64'd89, 1'b0, 1'b0);
    do_start(2, 15, 1);
    feed_str(lines4[1], 0);
    wait_idle("after_rst");

    repeat (3) @(negedge sysclk);
    check64("queue_drained", 64'(exp_q.size()), 64'd0);
    check64("done_count", 64'(n_done), 64'(n_jobs));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
